// File: rtl/point_collector_pkg.sv
// Shared point-overlay definitions: level encodings, sprite sizes and the point coordinate table.
package point_collector_pkg;

  localparam int unsigned COORD_W    = 11;
  localparam int unsigned CMP_W      = 12;
  localparam int unsigned LVL_W      = 3;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned NUM_POINTS = 5;
  localparam int unsigned PT_W       = 16;
  localparam int unsigned PT_H       = 16;

  localparam logic [LVL_W-1:0] LVL1 = 3'd1;
  localparam logic [LVL_W-1:0] LVL2 = 3'd2;
  localparam logic [LVL_W-1:0] LVL3 = 3'd3;

  typedef enum logic {
    S_IDLE,
    S_CHECK
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } point_pos_t;

  function automatic logic lvl_valid(input logic [LVL_W-1:0] lvl);
    return (lvl == LVL1) || (lvl == LVL2) || (lvl == LVL3);
  endfunction

  function automatic point_pos_t mk_pos(input int unsigned x, input int unsigned y);
    point_pos_t p;
    p.x = COORD_W'(x);
    p.y = COORD_W'(y);
    return p;
  endfunction

endpackage

// File: rtl/point_collector_lut.sv
// Combinational point position table indexed by level and point number; (0,0) for invalid inputs.
module point_pos_lut
  import point_collector_pkg::*;
(
  input  logic [LVL_W-1:0] lvl_i,
  input  logic [IDX_W-1:0] idx_i,
  output point_pos_t       pos_c
);

  always_comb begin
    pos_c = '0;
    case (lvl_i)
      LVL1: begin
        case (idx_i)
          3'd0:    pos_c = mk_pos(269, 216);
          3'd1:    pos_c = mk_pos(519, 116);
          3'd2:    pos_c = mk_pos(229, 496);
          3'd3:    pos_c = mk_pos(304, 454);
          3'd4:    pos_c = mk_pos(404, 546);
          default: pos_c = '0;
        endcase
      end
      LVL2: begin
        case (idx_i)
          3'd0:    pos_c = mk_pos(95, 330);
          3'd1:    pos_c = mk_pos(235, 100);
          3'd2:    pos_c = mk_pos(400, 240);
          3'd3:    pos_c = mk_pos(300, 460);
          3'd4:    pos_c = mk_pos(400, 550);
          default: pos_c = '0;
        endcase
      end
      LVL3: begin
        case (idx_i)
          3'd0:    pos_c = mk_pos(105, 120);
          3'd1:    pos_c = mk_pos(730, 300);
          3'd2:    pos_c = mk_pos(270, 350);
          3'd3:    pos_c = mk_pos(560, 150);
          3'd4:    pos_c = mk_pos(640, 110);
          default: pos_c = '0;
        endcase
      end
      default: pos_c = '0;
    endcase
  end

endmodule

// File: rtl/point_collector.sv
// Per-frame collision pass of the player box against the level's remaining points;
// owns point_enable, the saturating score and the level-complete flag.
module point_collector
  import point_collector_pkg::*;
#(
  parameter int unsigned PLAYER_W = 16,
  parameter int unsigned PLAYER_H = 16,
  parameter int unsigned POINT_W  = PT_W,
  parameter int unsigned POINT_H  = PT_H,
  parameter int unsigned SCORE_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [LVL_W-1:0]      lvl,
  input  logic                  lvl_load,
  input  logic                  vsync_in,
  input  logic [COORD_W-1:0]    player_x,
  input  logic [COORD_W-1:0]    player_y,
  output logic [NUM_POINTS-1:0] point_enable,
  output logic                  collected,
  output logic [SCORE_W-1:0]    score,
  output logic                  lvl_done
);

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    vsync_q;
  logic [COORD_W-1:0]      px_q, px_d, py_q, py_d;
  logic [NUM_POINTS-1:0]   en_q, en_d;
  logic [SCORE_W-1:0]      score_q, score_d;
  logic                    coll_q, coll_d;
  logic                    done_q, done_d;
  logic                    pend_q, pend_d;
  logic                    rise;
  logic                    hit;
  point_pos_t              pos;
  logic [CMP_W-1:0]        px12, py12, xk12, yk12;

  point_pos_lut u_lut (
    .lvl_i (lvl),
    .idx_i (idx_q),
    .pos_c (pos)
  );

  assign rise = vsync_in & ~vsync_q;
  assign px12 = CMP_W'(px_q);
  assign py12 = CMP_W'(py_q);
  assign xk12 = CMP_W'(pos.x);
  assign yk12 = CMP_W'(pos.y);

  // Strict-inequality box overlap: touching edges do not count as a hit.
  assign hit = en_q[idx_q]
             && (px12 < xk12 + CMP_W'(POINT_W))
             && (px12 + CMP_W'(PLAYER_W) > xk12)
             && (py12 < yk12 + CMP_W'(POINT_H))
             && (py12 + CMP_W'(PLAYER_H) > yk12);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      vsync_q <= 1'b0;
      px_q    <= '0;
      py_q    <= '0;
      en_q    <= '0;
      score_q <= '0;
      coll_q  <= 1'b0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      vsync_q <= vsync_in;
      px_q    <= px_d;
      py_q    <= py_d;
      en_q    <= en_d;
      score_q <= score_d;
      coll_q  <= coll_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    px_d    = px_q;
    py_d    = py_q;
    en_d    = en_q;
    score_d = score_q;
    coll_d  = 1'b0;
    done_d  = done_q;
    pend_d  = 1'b0;
    if (lvl_load) begin
      state_d = S_IDLE;
      idx_d   = '0;
      done_d  = 1'b0;
      en_d    = lvl_valid(lvl) ? '1 : '0;
    end else begin
      // pend_q marks the cycle after the last point of a pass has been resolved.
      if (pend_q && (en_q == '0)) done_d = 1'b1;
      case (state_q)
        S_IDLE: begin
          if (rise && lvl_valid(lvl)) begin
            px_d    = player_x;
            py_d    = player_y;
            idx_d   = '0;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (hit) begin
            en_d[idx_q] = 1'b0;
            coll_d      = 1'b1;
            if (score_q != {SCORE_W{1'b1}}) score_d = score_q + SCORE_W'(1);
          end
          if (idx_q == IDX_W'(NUM_POINTS - 1)) begin
            state_d = S_IDLE;
            idx_d   = '0;
            pend_d  = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign point_enable = en_q;
  assign collected    = coll_q;
  assign score        = score_q;
  assign lvl_done     = done_q;

endmodule

// File: tb/tb_point_collector.sv
// Scoreboard bench for point_collector: directed frames push expected collect events,
// a negedge monitor pops and compares them whenever collected pulses.
module tb_point_collector;

  typedef struct {
    logic [4:0] en;
    logic [7:0] score;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  lvl;
  logic        lvl_load;
  logic        vsync_in;
  logic [10:0] player_x;
  logic [10:0] player_y;
  logic [4:0]  point_enable;
  logic        collected;
  logic [7:0]  score;
  logic        lvl_done;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];

  point_collector dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lvl          (lvl),
    .lvl_load     (lvl_load),
    .vsync_in     (vsync_in),
    .player_x     (player_x),
    .player_y     (player_y),
    .point_enable (point_enable),
    .collected    (collected),
    .score        (score),
    .lvl_done     (lvl_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [2:0] l);
    lvl      = l;
    lvl_load = 1'b1;
    tick(1);
    lvl_load = 1'b0;
  endtask

  task automatic push(input logic [4:0] en, input logic [7:0] sc);
    exp_t e;
    e.en    = en;
    e.score = sc;
    exp_q.push_back(e);
  endtask

  task automatic frame(input int x, input int y);
    player_x = 11'(x);
    player_y = 11'(y);
    vsync_in = 1'b1;
    tick(2);
    vsync_in = 1'b0;
    tick(10);
  endtask

  always @(negedge clk) begin
    if (rst_n && collected) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_collect: got pulse with en=%b score=%0d, expected no pulse",
                 point_enable, score);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("collect_en", 32'(point_enable), 32'(e.en));
        check("collect_score", 32'(score), 32'(e.score));
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    lvl      = 3'd0;
    lvl_load = 1'b0;
    vsync_in = 1'b0;
    player_x = '0;
    player_y = '0;
    tick(2);
    check("rst_en", 32'(point_enable), 32'h0);
    check("rst_score", 32'(score), 32'h0);
    check("rst_done", 32'(lvl_done), 32'h0);
    check("rst_coll", 32'(collected), 32'h0);
    rst_n = 1'b1;
    tick(1);

    load(3'd1);
    check("load1_en", 32'(point_enable), 32'h1f);
    check("load1_score", 32'(score), 32'h0);
    check("load1_done", 32'(lvl_done), 32'h0);

    // Exact collect timing on point 0 of level 1.
    push(5'b11110, 8'd1);
    player_x = 11'd270;
    player_y = 11'd220;
    vsync_in = 1'b1;
    tick(1);
    check("e0_en", 32'(point_enable), 32'h1f);
    tick(1);
    check("e1_en", 32'(point_enable), 32'h1e);
    check("e1_coll", 32'(collected), 32'h1);
    vsync_in = 1'b0;
    tick(10);
    check("hit0_score", 32'(score), 32'd1);

    // Edge touch versus one-pixel overlap.
    load(3'd1);
    frame(253, 216);
    check("touch_en", 32'(point_enable), 32'h1f);
    check("touch_score", 32'(score), 32'd1);
    push(5'b11110, 8'd2);
    frame(254, 216);
    check("overlap_en", 32'(point_enable), 32'h1e);

    // Clear the whole level over five frames.
    load(3'd1);
    check("reload_score", 32'(score), 32'd2);
    push(5'b11110, 8'd3); frame(269, 216);
    push(5'b11100, 8'd4); frame(519, 116);
    push(5'b11000, 8'd5); frame(229, 496);
    push(5'b10000, 8'd6); frame(304, 454);
    check("pre_last_done", 32'(lvl_done), 32'h0);
    push(5'b00000, 8'd7);
    player_x = 11'd404;
    player_y = 11'd546;
    vsync_in = 1'b1;
    tick(1);
    vsync_in = 1'b0;
    tick(5);
    check("e5_en", 32'(point_enable), 32'h0);
    check("e5_done", 32'(lvl_done), 32'h0);
    tick(1);
    check("e6_done", 32'(lvl_done), 32'h1);
    tick(5);
    check("all_score", 32'(score), 32'd7);

    load(3'd2);
    check("load2_en", 32'(point_enable), 32'h1f);
    check("load2_done", 32'(lvl_done), 32'h0);
    check("load2_score", 32'(score), 32'd7);

    // Second rise registered at E2 while checking is ignored.
    push(5'b11110, 8'd8);
    player_x = 11'd95;
    player_y = 11'd330;
    vsync_in = 1'b1;
    tick(1);
    vsync_in = 1'b0;
    tick(1);
    vsync_in = 1'b1;
    tick(1);
    vsync_in = 1'b0;
    tick(12);
    check("dbl_score", 32'(score), 32'd8);
    check("dbl_en", 32'(point_enable), 32'h1e);

    // Load coincident with rise: reload wins and no pass runs.
    player_x = 11'd235;
    player_y = 11'd100;
    vsync_in = 1'b1;
    lvl_load = 1'b1;
    tick(1);
    lvl_load = 1'b0;
    tick(1);
    vsync_in = 1'b0;
    tick(10);
    check("coinc_en", 32'(point_enable), 32'h1f);
    check("coinc_score", 32'(score), 32'd8);

    // Invalid level.
    load(3'd7);
    check("inv_en", 32'(point_enable), 32'h0);
    frame(269, 216);
    check("inv_en_after", 32'(point_enable), 32'h0);
    check("inv_score", 32'(score), 32'd8);
    check("inv_done", 32'(lvl_done), 32'h0);

    // Asynchronous reset in the middle of a pass.
    load(3'd3);
    check("load3_en", 32'(point_enable), 32'h1f);
    player_x = 11'd640;
    player_y = 11'd110;
    vsync_in = 1'b1;
    tick(3);
    rst_n = 1'b0;
    #1;
    check("arst_en", 32'(point_enable), 32'h0);
    check("arst_score", 32'(score), 32'h0);
    check("arst_coll", 32'(collected), 32'h0);
    check("arst_done", 32'(lvl_done), 32'h0);
    vsync_in = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check("post_rst_en", 32'(point_enable), 32'h0);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
